// File: rtl/mem_router_pkg.sv
// Shared definitions for the core data-port router: FSM encoding and port-index sizing.
package mem_router_pkg;

  typedef logic [1:0] state_t;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ISSUE = 2'd1;
  localparam logic [1:0] ST_WAIT  = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  // A single port still needs a one-bit index so vectors never collapse to zero width.
  function automatic int port_idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/mem_router_if.sv
// Downstream request/response bus between the router and its per-target adapters.
interface mem_router_if #(
  parameter int NUM_PORTS  = 3,
  parameter int ADDR_WIDTH = 64,
  parameter int DATA_WIDTH = 64
);
  logic [NUM_PORTS-1:0]            req_valid;
  logic [NUM_PORTS-1:0]            req_ready;
  logic                            req_we;
  logic [ADDR_WIDTH-1:0]           req_addr;
  logic [DATA_WIDTH-1:0]           req_wdata;
  logic [DATA_WIDTH/8-1:0]         req_wmask;
  logic [NUM_PORTS-1:0]            rsp_valid;
  logic [NUM_PORTS*DATA_WIDTH-1:0] rsp_rdata;

  modport master (
    output req_valid, req_we, req_addr, req_wdata, req_wmask,
    input  req_ready, rsp_valid, rsp_rdata
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, req_wmask,
    output req_ready, rsp_valid, rsp_rdata
  );
endinterface

// File: rtl/mem_region_decode.sv
// Combinational address decode against programmable base/mask regions; lowest index wins.
module mem_region_decode
  import mem_router_pkg::*;
#(
  parameter int                            NUM_PORTS   = 3,
  parameter int                            ADDR_WIDTH  = 64,
  parameter logic [NUM_PORTS*ADDR_WIDTH-1:0] REGION_BASE = '0,
  parameter logic [NUM_PORTS*ADDR_WIDTH-1:0] REGION_MASK = '0,
  parameter int                            IDX_W       = port_idx_w(NUM_PORTS)
) (
  input  logic [ADDR_WIDTH-1:0] i_addr,
  output logic                  o_hit,
  output logic [IDX_W-1:0]      o_idx
);

  // Scanning downward lets the lowest hitting index overwrite any higher one.
  always_comb begin
    o_hit = 1'b0;
    o_idx = '0;
    for (int i = NUM_PORTS - 1; i >= 0; i--) begin
      if ((i_addr & REGION_MASK[i*ADDR_WIDTH +: ADDR_WIDTH]) ==
          REGION_BASE[i*ADDR_WIDTH +: ADDR_WIDTH]) begin
        o_hit = 1'b1;
        o_idx = IDX_W'(i);
      end
    end
  end

endmodule

// File: rtl/mem_router.sv
// Routes core data accesses to one of NUM_PORTS downstream targets, with unmapped
// faults, a per-access timeout and discard of responses that arrive after a timeout.
module mem_router
  import mem_router_pkg::*;
#(
  parameter int                              NUM_PORTS   = 3,
  parameter int                              ADDR_WIDTH  = 64,
  parameter int                              DATA_WIDTH  = 64,
  parameter logic [NUM_PORTS*ADDR_WIDTH-1:0] REGION_BASE = '0,
  parameter logic [NUM_PORTS*ADDR_WIDTH-1:0] REGION_MASK = '0,
  parameter int                              TIMEOUT     = 1024
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [ADDR_WIDTH-1:0]   addr_cpu,
  input  logic                    wen_cpu,
  input  logic                    ren_cpu,
  input  logic [DATA_WIDTH-1:0]   wdata_cpu,
  input  logic [DATA_WIDTH/8-1:0] wmask_cpu,
  output logic [DATA_WIDTH-1:0]   rdata_cpu,
  output logic                    stall_cpu,
  output logic                    fault_cpu,
  mem_router_if.master            bus
);

  localparam int IDX_W  = port_idx_w(NUM_PORTS);
  localparam int MASK_W = DATA_WIDTH / 8;
  localparam int CNT_W  = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  typedef struct packed {
    logic                  we;
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] wdata;
    logic [MASK_W-1:0]     wmask;
  } mem_req_t;

  state_t                r_state;
  logic [IDX_W-1:0]      r_sel;
  mem_req_t              r_req;
  logic [DATA_WIDTH-1:0] r_rdata;
  logic                  r_fault;
  logic [CNT_W-1:0]      r_cnt;
  logic [NUM_PORTS-1:0]  r_pending;

  logic                  w_hit;
  logic [IDX_W-1:0]      w_idx;
  logic [NUM_PORTS-1:0]  w_sel_oh;
  logic                  w_blocked;
  logic                  w_accept;
  logic                  w_rsp_sel;
  logic                  w_tmo;
  logic [DATA_WIDTH-1:0] w_rsp_data;

  mem_region_decode #(
    .NUM_PORTS  (NUM_PORTS),
    .ADDR_WIDTH (ADDR_WIDTH),
    .REGION_BASE(REGION_BASE),
    .REGION_MASK(REGION_MASK),
    .IDX_W      (IDX_W)
  ) u_decode (
    .i_addr(addr_cpu),
    .o_hit (w_hit),
    .o_idx (w_idx)
  );

  always_comb begin
    w_sel_oh        = '0;
    w_sel_oh[r_sel] = 1'b1;
  end

  // A port still owing a response from a timed-out access is fenced off until it answers.
  assign w_blocked  = r_pending[r_sel];
  assign w_accept   = (r_state == ST_ISSUE) && !w_blocked && bus.req_ready[r_sel];
  assign w_rsp_sel  = bus.rsp_valid[r_sel];
  assign w_rsp_data = bus.rsp_rdata[r_sel*DATA_WIDTH +: DATA_WIDTH];
  assign w_tmo      = (TIMEOUT != 0) && (r_cnt == CNT_W'(TIMEOUT - 1));

  assign bus.req_valid = ((r_state == ST_ISSUE) && !w_blocked) ? w_sel_oh : '0;
  assign bus.req_we    = r_req.we;
  assign bus.req_addr  = r_req.addr;
  assign bus.req_wdata = r_req.wdata;
  assign bus.req_wmask = r_req.wmask;

  assign stall_cpu = (wen_cpu | ren_cpu) && (r_state != ST_DONE);
  assign rdata_cpu = r_rdata;
  assign fault_cpu = r_fault;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= ST_IDLE;
      r_sel     <= '0;
      r_req     <= '0;
      r_rdata   <= '0;
      r_fault   <= 1'b0;
      r_cnt     <= '0;
      r_pending <= '0;
    end else begin
      r_pending <= r_pending & ~bus.rsp_valid;
      case (r_state)
        ST_IDLE: begin
          if (wen_cpu | ren_cpu) begin
            r_sel       <= w_idx;
            r_req.we    <= wen_cpu;
            r_req.addr  <= addr_cpu;
            r_req.wdata <= wdata_cpu;
            r_req.wmask <= wmask_cpu;
            r_cnt       <= '0;
            r_rdata     <= '0;
            r_fault     <= !w_hit;
            r_state     <= w_hit ? ST_ISSUE : ST_DONE;
          end
        end
        ST_ISSUE, ST_WAIT: begin
          r_cnt <= r_cnt + 1'b1;
          // A response on the final timeout cycle still completes the access normally.
          if (((r_state == ST_WAIT) || w_accept) && w_rsp_sel) begin
            r_rdata <= r_req.we ? '0 : w_rsp_data;
            r_state <= ST_DONE;
          end else if (w_tmo) begin
            r_fault <= 1'b1;
            r_rdata <= '0;
            r_state <= ST_DONE;
            if ((r_state == ST_WAIT) || w_accept)
              r_pending <= (r_pending & ~bus.rsp_valid) | w_sel_oh;
          end else if (w_accept) begin
            r_state <= ST_WAIT;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_router.sv
// Randomized transaction-level bench for mem_router against a cycle-count reference model.
module tb_mem_router;

  localparam int NP    = 3;
  localparam int AW    = 32;
  localparam int DW    = 32;
  localparam int MW    = DW / 8;
  localparam int T     = 8;
  localparam int NEVER = 1000;

  localparam logic [NP*AW-1:0] BASE = {32'h0200_0000, 32'h1000_0000, 32'h8000_0000};
  localparam logic [NP*AW-1:0] MASK = {32'hFF00_0000, 32'h7000_0000, 32'hE000_0000};

  logic [AW-1:0] m_base [NP] = '{32'h8000_0000, 32'h1000_0000, 32'h0200_0000};
  logic [AW-1:0] m_mask [NP] = '{32'hE000_0000, 32'h7000_0000, 32'hFF00_0000};

  logic          clk = 1'b0;
  logic          rst;
  logic [AW-1:0] addr_cpu;
  logic          wen_cpu, ren_cpu;
  logic [DW-1:0] wdata_cpu;
  logic [MW-1:0] wmask_cpu;
  logic [DW-1:0] rdata_cpu;
  logic          stall_cpu, fault_cpu;

  mem_router_if #(.NUM_PORTS(NP), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  mem_router #(
    .NUM_PORTS(NP), .ADDR_WIDTH(AW), .DATA_WIDTH(DW),
    .REGION_BASE(BASE), .REGION_MASK(MASK), .TIMEOUT(T)
  ) dut (
    .clk(clk), .rst(rst),
    .addr_cpu(addr_cpu), .wen_cpu(wen_cpu), .ren_cpu(ren_cpu),
    .wdata_cpu(wdata_cpu), .wmask_cpu(wmask_cpu),
    .rdata_cpu(rdata_cpu), .stall_cpu(stall_cpu), .fault_cpu(fault_cpu),
    .bus(bus)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Per-cycle expectations published by the stimulus process.
  bit            cmp_en = 1'b0;
  logic          exp_stall;
  logic [NP-1:0] exp_reqv;
  bit            exp_done;
  logic          exp_fault;
  logic [DW-1:0] exp_rdata;
  logic [AW-1:0] exp_addr;
  logic          exp_we;
  logic [DW-1:0] exp_wd;
  logic [MW-1:0] exp_wm;
  logic [DW-1:0] last_rdata;
  logic          last_fault;

  bit pend [NP];

  initial forever begin
    @(negedge clk);
    if (cmp_en) begin
      chk("stall_cpu", stall_cpu, exp_stall);
      chk("req_valid", bus.req_valid, exp_reqv);
      if (exp_reqv != '0) begin
        chk("req_addr", bus.req_addr, exp_addr);
        chk("req_we", bus.req_we, exp_we);
        chk("req_wdata", bus.req_wdata, exp_wd);
        chk("req_wmask", bus.req_wmask, exp_wm);
      end
      if (exp_done) begin
        chk("fault_cpu", fault_cpu, exp_fault);
        chk("rdata_cpu", rdata_cpu, exp_rdata);
        last_rdata = rdata_cpu;
        last_fault = fault_cpu;
      end
    end
  end

  task automatic idle_cycles(input int n);
    for (int k = 0; k < n; k++) begin
      wen_cpu = 1'b0; ren_cpu = 1'b0;
      bus.req_ready = '0; bus.rsp_valid = '0;
      exp_stall = 1'b0; exp_reqv = '0; exp_done = 1'b0;
      cmp_en = 1'b1;
      @(posedge clk); #1;
    end
  endtask

  // One core access. The model works in cycle numbers relative to the request cycle (0):
  // issue is visible from cycle 1 (or one cycle after a late response unblocks the port),
  // a response at cycle <= T completes, otherwise the access times out at cycle T.
  task automatic run_txn(input logic [AW-1:0] addr, input bit we, input logic [DW-1:0] wd,
                         input logic [MW-1:0] wm, input int rdy_dly, input int rsp_dly,
                         input logic [DW-1:0] rd, input int late_port, input int late_cyc,
                         input bit noise, output int o_done, output int o_port);
    int p, q, unblock, accept, rspc, done;
    bit hit, ok;
    hit = 1'b0; p = 0;
    for (int i = 0; i < NP; i++)
      if (!hit && ((addr & m_mask[i]) == m_base[i])) begin hit = 1'b1; p = i; end
    unblock = 1;
    if (hit && pend[p]) unblock = (late_port == p) ? ((late_cyc < 1) ? 1 : late_cyc + 1) : NEVER;
    accept = (unblock >= NEVER) ? NEVER : unblock + rdy_dly;
    rspc   = (rsp_dly < 0 || accept >= NEVER) ? NEVER : accept + rsp_dly;
    ok     = hit && (rspc <= T);
    done   = !hit ? 1 : (ok ? rspc + 1 : T + 1);
    o_done = done;
    o_port = hit ? p : -1;
    for (int k = 0; k <= done; k++) begin
      addr_cpu = addr; wen_cpu = we; ren_cpu = !we; wdata_cpu = wd; wmask_cpu = wm;
      bus.req_ready = '0; bus.rsp_valid = '0;
      for (int i = 0; i < NP; i++) bus.rsp_rdata[i*DW +: DW] = $urandom;
      if (noise) begin
        for (int i = 0; i < NP; i++)
          if (!(hit && i == p)) bus.req_ready[i] = 1'($urandom_range(0, 1));
      end
      if (hit && k == accept && accept <= T) bus.req_ready[p] = 1'b1;
      if (ok && k == rspc) begin
        bus.rsp_valid[p] = 1'b1;
        bus.rsp_rdata[p*DW +: DW] = rd;
      end
      if (late_port >= 0 && k == late_cyc && pend[late_port]) begin
        bus.rsp_valid[late_port] = 1'b1;
        pend[late_port] = 1'b0;
      end
      if (noise && $urandom_range(0, 2) == 0) begin
        q = $urandom_range(0, NP - 1);
        if (!(hit && q == p) && !pend[q] && q != late_port) bus.rsp_valid[q] = 1'b1;
      end
      exp_stall = (k < done);
      exp_reqv  = '0;
      if (hit && k >= unblock && k <= accept && k < done) exp_reqv[p] = 1'b1;
      exp_addr  = addr; exp_we = we; exp_wd = wd; exp_wm = wm;
      exp_done  = (k == done);
      exp_fault = !ok;
      exp_rdata = (ok && !we) ? rd : '0;
      cmp_en    = 1'b1;
      @(posedge clk); #1;
    end
    if (hit && !ok && accept <= T) pend[p] = 1'b1;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1);
  end

  initial begin
    int d, pt, late_p, late_c, rsp_d;
    logic [31:0] r;
    logic [AW-1:0] a;

    rst = 1'b1;
    addr_cpu = 32'h8000_0000; wen_cpu = 1'b0; ren_cpu = 1'b1;
    wdata_cpu = '0; wmask_cpu = '0;
    bus.req_ready = '0; bus.rsp_valid = '0; bus.rsp_rdata = '0;
    for (int i = 0; i < NP; i++) pend[i] = 1'b0;

    @(posedge clk); @(posedge clk);
    @(negedge clk);
    chk("rst_stall_req", stall_cpu, 1'b1);
    chk("rst_req_valid", bus.req_valid, '0);
    chk("rst_req_we", bus.req_we, 1'b0);
    chk("rst_req_addr", bus.req_addr, '0);
    chk("rst_req_wdata", bus.req_wdata, '0);
    chk("rst_req_wmask", bus.req_wmask, '0);
    chk("rst_rdata", rdata_cpu, '0);
    chk("rst_fault", fault_cpu, 1'b0);
    ren_cpu = 1'b0; #1;
    chk("rst_stall_noreq", stall_cpu, 1'b0);
    @(posedge clk); #1;
    rst = 1'b0;

    // Minimum-latency read on port 0.
    run_txn(32'h8000_0010, 1'b0, 32'h0, 4'h0, 0, 0, 32'h0000_DEAD, -1, 0, 1'b0, d, pt);
    chk("pin_min_latency", d, 2);
    chk("pin_min_rdata", last_rdata, 32'h0000_DEAD);
    chk("pin_min_port", pt, 0);

    // Write with ready delayed 3 cycles and response 2 cycles after acceptance.
    run_txn(32'h1000_0008, 1'b1, 32'h55, 4'h1, 3, 2, 32'hFFFF_FFFF, -1, 0, 1'b0, d, pt);
    chk("pin_write_done", d, 7);
    chk("pin_write_port", pt, 1);
    chk("pin_write_rdata", last_rdata, 32'h0);
    idle_cycles(1);

    // Unmapped access.
    run_txn(32'h4000_0000, 1'b0, 32'h0, 4'h0, 0, 0, 32'h1234, -1, 0, 1'b0, d, pt);
    chk("pin_unmapped_done", d, 1);
    chk("pin_unmapped_fault", last_fault, 1'b1);

    // Overlapping regions 0 and 1: port 0 wins.
    run_txn(32'h9000_0040, 1'b0, 32'h0, 4'h0, 1, 1, 32'hCAFE_0001, -1, 0, 1'b1, d, pt);
    chk("pin_overlap_port", pt, 0);

    // Port 2 accepts but never answers, then stays blocked, then a late response frees it.
    run_txn(32'h0200_0100, 1'b0, 32'h0, 4'h0, 0, -1, 32'h0, -1, 0, 1'b0, d, pt);
    chk("pin_timeout_done", d, T + 1);
    chk("pin_timeout_fault", last_fault, 1'b1);
    run_txn(32'h0200_0200, 1'b0, 32'h0, 4'h0, 0, 0, 32'h0, -1, 0, 1'b0, d, pt);
    chk("pin_blocked_done", d, T + 1);
    run_txn(32'h0200_0300, 1'b0, 32'h0, 4'h0, 0, 1, 32'hBEEF_0002, 2, 3, 1'b0, d, pt);
    chk("pin_unblock_done", d, 6);
    chk("pin_unblock_rdata", last_rdata, 32'hBEEF_0002);
    idle_cycles(1);

    // Leave port 1 pending, then reset in the middle of a port-0 access.
    run_txn(32'h1000_0000, 1'b1, 32'h7, 4'hF, 0, -1, 32'h0, -1, 0, 1'b0, d, pt);
    cmp_en = 1'b0;
    addr_cpu = 32'h8000_0020; ren_cpu = 1'b1; wen_cpu = 1'b0;
    bus.req_ready = '0; bus.rsp_valid = '0;
    @(posedge clk); #1;
    bus.req_ready = 3'b001;
    @(negedge clk);
    chk("rw_issue_valid", bus.req_valid, 3'b001);
    @(posedge clk); #1;
    bus.req_ready = '0;
    @(negedge clk);
    chk("rw_wait_valid", bus.req_valid, 3'b000);
    chk("rw_wait_stall", stall_cpu, 1'b1);
    chk("rw_wait_addr", bus.req_addr, 32'h8000_0020);
    @(posedge clk); #1;
    rst = 1'b1; ren_cpu = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    chk("rw_rst_stall", stall_cpu, 1'b0);
    chk("rw_rst_valid", bus.req_valid, 3'b000);
    chk("rw_rst_addr", bus.req_addr, 32'h0);
    chk("rw_rst_we", bus.req_we, 1'b0);
    chk("rw_rst_rdata", rdata_cpu, 32'h0);
    chk("rw_rst_fault", fault_cpu, 1'b0);
    @(posedge clk); #1;
    rst = 1'b0;
    for (int i = 0; i < NP; i++) pend[i] = 1'b0;
    run_txn(32'h1000_0010, 1'b0, 32'h0, 4'h0, 0, 0, 32'hA5A5_0003, -1, 0, 1'b0, d, pt);
    chk("pin_after_rst_done", d, 2);

    // Randomized traffic.
    for (int n = 0; n < 150; n++) begin
      r = $urandom;
      case ($urandom_range(0, 4))
        0:       a = {3'b100, r[28:0]};
        1:       a = {4'b0001, r[27:0]};
        2:       a = {8'h02, r[23:0]};
        3:       a = {4'b1001, r[27:0]};
        default: a = r;
      endcase
      rsp_d  = ($urandom_range(0, 7) == 0) ? -1 : int'($urandom_range(0, 3));
      late_p = -1;
      late_c = 0;
      if ($urandom_range(0, 1) == 1) begin
        for (int i = 0; i < NP; i++) if (pend[i] && late_p < 0) late_p = i;
        late_c = $urandom_range(0, 5);
      end
      run_txn(a, 1'($urandom_range(0, 1)), $urandom, 4'($urandom), $urandom_range(0, 3),
              rsp_d, $urandom, late_p, late_c, 1'b1, d, pt);
      idle_cycles($urandom_range(0, 1));
    end

    cmp_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
